// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access sequencer: FSM encoding,
// strobe-timer width and the default strobe length.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam int STROBE_CYCLES_DEF = 2;
    localparam int TIMER_W           = 4;

    // The timer counts down to zero, so it is loaded with one less than the strobe length.
    function automatic logic [TIMER_W-1:0] strobe_load(input int cycles);
        int c;
        c = cycles - 1;
        return c[TIMER_W-1:0];
    endfunction

endpackage

// File: rtl/access_timer.sv
// Down-counter timing the select strobe; done flags that the count has reached zero.
module access_timer
    import mem_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic               done,
    output logic [TIMER_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/memory_access_sequencer.sv
// Sequences single read/write accesses to a small bitcell array (SETUP, STROBE, HOLD, RESP).
// Optional macro WRITE_VERIFY_EN adds a read-back verify pass after every write.
module memory_access_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter int STROBE_CYCLES = STROBE_CYCLES_DEF,
    parameter int DATA_W        = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              adr0,
    output logic              adr1,
    output logic              adr2,
    output logic              select,
    output logic              wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [TIMER_W-1:0] STROBE_LOAD = strobe_load(STROBE_CYCLES);

    state_t              state, state_nx;
    logic [2:0]          addr_p0;
    logic                write_p0;
    logic [DATA_W-1:0]   wdata_p0;
    logic [DATA_W-1:0]   rdata_p1;
    logic [DATA_W-1:0]   rsp_rdata_r;
    logic                accept, capture, resp_load;
    logic                t_load, t_en, t_done;
    logic [TIMER_W-1:0]  t_count;
`ifdef WRITE_VERIFY_EN
    logic                vfy_p0, turn_p0, rsp_err_r;
`endif

    assign accept    = (state == ST_IDLE) && req_valid;
    assign t_load    = (state == ST_SETUP);
    assign t_en      = (state == ST_STROBE) && (t_count != '0);
    assign resp_load = (state == ST_HOLD) && (state_nx == ST_RESP);
`ifdef WRITE_VERIFY_EN
    assign capture   = (state == ST_STROBE) && t_done && (!write_p0 || vfy_p0);
`else
    assign capture   = (state == ST_STROBE) && t_done && !write_p0;
`endif

    access_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (STROBE_LOAD),
        .en       (t_en),
        .done     (t_done),
        .count    (t_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (req_valid) state_nx = ST_SETUP;
            ST_SETUP:  state_nx = ST_STROBE;
            ST_STROBE: if (t_done) state_nx = ST_HOLD;
`ifdef WRITE_VERIFY_EN
            // A write holds one extra turnaround cycle before re-running SETUP/STROBE/HOLD as a read.
            ST_HOLD:   if (write_p0 && !vfy_p0) state_nx = turn_p0 ? ST_SETUP : ST_HOLD;
                       else                     state_nx = ST_RESP;
`else
            ST_HOLD:   state_nx = ST_RESP;
`endif
            ST_RESP:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        select    = (state == ST_STROBE);
        rsp_valid = (state == ST_RESP);
`ifdef WRITE_VERIFY_EN
        wr_en     = (state == ST_STROBE) && write_p0 && !vfy_p0;
`else
        wr_en     = (state == ST_STROBE) && write_p0;
`endif
    end

    // Request registers, strobe capture and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p0     <= '0;
            write_p0    <= 1'b0;
            wdata_p0    <= '0;
            rdata_p1    <= '0;
            rsp_rdata_r <= '0;
`ifdef WRITE_VERIFY_EN
            vfy_p0      <= 1'b0;
            turn_p0     <= 1'b0;
            rsp_err_r   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                addr_p0  <= req_addr;
                write_p0 <= req_write;
                wdata_p0 <= req_wdata;
`ifdef WRITE_VERIFY_EN
                vfy_p0   <= 1'b0;
                turn_p0  <= 1'b0;
`endif
            end
            if (capture) rdata_p1 <= mem_rdata;
`ifdef WRITE_VERIFY_EN
            if (state == ST_HOLD && write_p0 && !vfy_p0) begin
                if (!turn_p0) turn_p0 <= 1'b1;
                else          vfy_p0  <= 1'b1;
            end
            if (resp_load) rsp_err_r <= write_p0 && (rdata_p1 != wdata_p0);
`endif
            if (resp_load && !write_p0) rsp_rdata_r <= rdata_p1;
        end
    end

    assign {adr0, adr1, adr2} = addr_p0;
    assign mem_wdata          = wdata_p0;
    assign rsp_rdata          = rsp_rdata_r;
`ifdef WRITE_VERIFY_EN
    assign rsp_err            = rsp_err_r;
`else
    assign rsp_err            = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Directed bench for memory_access_sequencer: default instance plus STROBE_CYCLES=1 and 15 instances.
module tb_memory_access_sequencer;

    localparam int SC = 2;
`ifdef WRITE_VERIFY_EN
    localparam int LAT_W  = 2*SC + 6;
    localparam int SELW_W = 2*SC;
    localparam bit VFY    = 1'b1;
`else
    localparam int LAT_W  = SC + 3;
    localparam int SELW_W = SC;
    localparam bit VFY    = 1'b0;
`endif
    localparam int LAT_R  = SC + 3;

    logic       clk, rst_n;
    logic       req_valid, req_write, req_wdata, mem_rdata;
    logic [2:0] req_addr;
    logic       req_ready, rsp_valid, rsp_rdata, rsp_err;
    logic       adr0, adr1, adr2, select, wr_en, mem_wdata;

    logic v1, s1_ready, s1_rsp_valid, s1_rdata, s1_err, s1_a0, s1_a1, s1_a2, s1_sel, s1_wr, s1_wd;
    logic v15, s15_ready, s15_rsp_valid, s15_rdata, s15_err, s15_a0, s15_a1, s15_a2, s15_sel, s15_wr, s15_wd;

    int tests = 0;
    int fails = 0;
    int obs_lat, obs_selw, obs_wrw, obs_rspw, obs_bad;
    logic obs_rdata, obs_err;

    memory_access_sequencer #(.STROBE_CYCLES(SC), .DATA_W(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .adr0(adr0), .adr1(adr1), .adr2(adr2), .select(select), .wr_en(wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    memory_access_sequencer #(.STROBE_CYCLES(1), .DATA_W(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(s1_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(s1_rsp_valid), .rsp_rdata(s1_rdata), .rsp_err(s1_err),
        .adr0(s1_a0), .adr1(s1_a1), .adr2(s1_a2), .select(s1_sel), .wr_en(s1_wr),
        .mem_wdata(s1_wd), .mem_rdata(mem_rdata)
    );

    memory_access_sequencer #(.STROBE_CYCLES(15), .DATA_W(1)) u_s15 (
        .clk(clk), .rst_n(rst_n), .req_valid(v15), .req_ready(s15_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(s15_rsp_valid), .rsp_rdata(s15_rdata), .rsp_err(s15_err),
        .adr0(s15_a0), .adr1(s15_a1), .adr2(s15_a2), .select(s15_sel), .wr_en(s15_wr),
        .mem_wdata(s15_wd), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one access on the default instance (assumed idle) and records what it observed.
    task automatic run_access(input logic wr, input logic [2:0] a, input logic wd, input logic rd);
        obs_lat = -1; obs_selw = 0; obs_wrw = 0; obs_rspw = 0; obs_bad = 0;
        obs_rdata = 1'b0; obs_err = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; mem_rdata = rd;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (select) obs_selw++;
            if (wr_en) obs_wrw++;
            if (wr_en && !select) obs_bad++;
            if (obs_lat < 0 && ({adr0, adr1, adr2} !== a || mem_wdata !== wd)) obs_bad++;
            if (rsp_valid) begin
                obs_rspw++;
                if (obs_lat < 0) begin
                    obs_lat = k; obs_rdata = rsp_rdata; obs_err = rsp_err;
                end
            end else if (obs_lat >= 0) begin
                break;
            end
        end
    endtask

    task automatic test_reset();
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        tests++; if ({rsp_valid, rsp_rdata, rsp_err} !== 3'b000) begin fails++; $display("FAIL reset_rsp: got %b expected 000", {rsp_valid, rsp_rdata, rsp_err}); end
        tests++; if ({adr0, adr1, adr2, select, wr_en, mem_wdata} !== 6'b0) begin fails++; $display("FAIL reset_mem_if: got %b expected 000000", {adr0, adr1, adr2, select, wr_en, mem_wdata}); end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL idle_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_write();
        run_access(1'b1, 3'b101, 1'b1, 1'b1);
        tests++; if (obs_lat !== LAT_W) begin fails++; $display("FAIL write_latency: got %0d expected %0d", obs_lat, LAT_W); end
        tests++; if (obs_selw !== SELW_W) begin fails++; $display("FAIL write_select_width: got %0d expected %0d", obs_selw, SELW_W); end
        tests++; if (obs_wrw !== SC) begin fails++; $display("FAIL write_wr_en_width: got %0d expected %0d", obs_wrw, SC); end
        tests++; if (obs_bad !== 0) begin fails++; $display("FAIL write_addr_stable: got %0d glitches expected 0", obs_bad); end
        tests++; if (obs_rspw !== 1) begin fails++; $display("FAIL write_rsp_width: got %0d expected 1", obs_rspw); end
        tests++; if (obs_err !== 1'b0) begin fails++; $display("FAIL write_err: got %b expected 0", obs_err); end
        tests++; if ({adr0, adr1, adr2} !== 3'b101) begin fails++; $display("FAIL write_adr_bits: got %b expected 101", {adr0, adr1, adr2}); end
        tests++; if (obs_rdata !== 1'b0) begin fails++; $display("FAIL write_keeps_rdata: got %b expected 0", obs_rdata); end
    endtask

    task automatic test_read();
        run_access(1'b0, 3'b010, 1'b0, 1'b1);
        tests++; if (obs_lat !== LAT_R) begin fails++; $display("FAIL read_latency: got %0d expected %0d", obs_lat, LAT_R); end
        tests++; if (obs_rdata !== 1'b1) begin fails++; $display("FAIL read_rdata1: got %b expected 1", obs_rdata); end
        tests++; if (obs_err !== 1'b0) begin fails++; $display("FAIL read_err: got %b expected 0", obs_err); end
        tests++; if (obs_selw !== SC || obs_wrw !== 0) begin fails++; $display("FAIL read_strobe: got sel=%0d wr=%0d expected sel=%0d wr=0", obs_selw, obs_wrw, SC); end
        tests++; if (obs_bad !== 0) begin fails++; $display("FAIL read_addr_stable: got %0d glitches expected 0", obs_bad); end
        run_access(1'b1, 3'b100, 1'b0, 1'b0);
        tests++; if (obs_rdata !== 1'b1) begin fails++; $display("FAIL rdata_held_over_write: got %b expected 1", obs_rdata); end
        run_access(1'b0, 3'b111, 1'b0, 1'b0);
        tests++; if (obs_rdata !== 1'b0) begin fails++; $display("FAIL read_rdata0: got %b expected 0", obs_rdata); end
    endtask

    task automatic test_verify();
        run_access(1'b1, 3'b011, 1'b1, 1'b0);
        tests++; if (obs_lat !== LAT_W) begin fails++; $display("FAIL verify_latency: got %0d expected %0d", obs_lat, LAT_W); end
        tests++; if (obs_err !== VFY) begin fails++; $display("FAIL verify_err: got %b expected %b", obs_err, VFY); end
    endtask

    task automatic test_back_to_back();
        int rsp1, rsp2, acc2, sel_total, sel_gap;
        rsp1 = -1; rsp2 = -1; acc2 = -1; sel_total = 0; sel_gap = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'b001; req_wdata = 1'b1; mem_rdata = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) begin req_write = 1'b0; req_addr = 3'b110; end
            if (acc2 >= 0 && k == acc2 + 1) req_valid = 1'b0;
            if (req_ready && acc2 < 0) acc2 = k;
            if (select) sel_total++;
            if (select && rsp1 >= 0 && (acc2 < 0 || k <= acc2 + 1)) sel_gap++;
            if (rsp_valid) begin
                if (rsp1 < 0) rsp1 = k;
                else if (rsp2 < 0) rsp2 = k;
            end
            if (rsp2 >= 0) break;
        end
        req_valid = 1'b0;
        tests++; if (rsp1 !== LAT_W) begin fails++; $display("FAIL b2b_first_rsp: got %0d expected %0d", rsp1, LAT_W); end
        tests++; if (acc2 !== LAT_W + 1) begin fails++; $display("FAIL b2b_second_accept: got %0d expected %0d", acc2, LAT_W + 1); end
        tests++; if (rsp2 !== LAT_W + 1 + LAT_R) begin fails++; $display("FAIL b2b_second_rsp: got %0d expected %0d", rsp2, LAT_W + 1 + LAT_R); end
        tests++; if (sel_total !== SELW_W + SC) begin fails++; $display("FAIL b2b_select_total: got %0d expected %0d", sel_total, SELW_W + SC); end
        tests++; if (sel_gap !== 0) begin fails++; $display("FAIL b2b_select_overlap: got %0d expected 0", sel_gap); end
        tests++; if (rsp_rdata !== 1'b1) begin fails++; $display("FAIL b2b_rdata: got %b expected 1", rsp_rdata); end
    endtask

    task automatic test_reset_mid();
        int rsp_cnt;
        rsp_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'b111; req_wdata = 1'b1; mem_rdata = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        tests++; if (select !== 1'b1) begin fails++; $display("FAIL mid_in_strobe: got %b expected 1", select); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({select, wr_en, rsp_valid, rsp_err} !== 4'b0000) begin fails++; $display("FAIL mid_reset_ctrl: got %b expected 0000", {select, wr_en, rsp_valid, rsp_err}); end
        tests++; if ({adr0, adr1, adr2, mem_wdata, rsp_rdata} !== 5'b0) begin fails++; $display("FAIL mid_reset_data: got %b expected 00000", {adr0, adr1, adr2, mem_wdata, rsp_rdata}); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_ready: got %b expected 1", req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
        end
        tests++; if (rsp_cnt !== 0) begin fails++; $display("FAIL mid_no_rsp: got %0d pulses expected 0", rsp_cnt); end
        run_access(1'b0, 3'b011, 1'b0, 1'b1);
        tests++; if (obs_lat !== LAT_R || obs_rdata !== 1'b1) begin fails++; $display("FAIL post_reset_read: got lat=%0d rdata=%b expected lat=%0d rdata=1", obs_lat, obs_rdata, LAT_R); end
    endtask

    task automatic test_strobe_width();
        int w1, w15, l1, l15;
        w1 = 0; w15 = 0; l1 = -1; l15 = -1;
        @(negedge clk);
        v1 = 1'b1; v15 = 1'b1; req_write = 1'b0; req_addr = 3'b100; mem_rdata = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            v1 = 1'b0; v15 = 1'b0;
            if (s1_sel) w1++;
            if (s15_sel) w15++;
            if (s1_rsp_valid && l1 < 0) l1 = k;
            if (s15_rsp_valid && l15 < 0) l15 = k;
            if (l1 >= 0 && l15 >= 0) break;
        end
        tests++; if (w1 !== 1) begin fails++; $display("FAIL sc1_select_width: got %0d expected 1", w1); end
        tests++; if (l1 !== 4) begin fails++; $display("FAIL sc1_latency: got %0d expected 4", l1); end
        tests++; if (w15 !== 15) begin fails++; $display("FAIL sc15_select_width: got %0d expected 15", w15); end
        tests++; if (l15 !== 18) begin fails++; $display("FAIL sc15_latency: got %0d expected 18", l15); end
        tests++; if (s15_rdata !== 1'b1) begin fails++; $display("FAIL sc15_rdata: got %b expected 1", s15_rdata); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 3'b000; req_wdata = 1'b0; mem_rdata = 1'b0;
        v1 = 1'b0; v15 = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_verify();
        test_back_to_back();
        test_reset_mid();
        test_strobe_width();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
